// File: rtl/regfile_pkg.sv
// Shared types and default sizes for the scoreboarded register file.
package regfile_pkg;

  typedef enum logic {
    RD_IDLE = 1'b0,
    RD_WAIT = 1'b1
  } rd_state_t;

  localparam int DATA_W_DEF   = 32;
  localparam int ADDR_W_DEF   = 4;
  localparam int RD_PORTS_DEF = 2;

endpackage

// File: rtl/regfile_read_port.sv
// One registered read port: issues immediately or parks in RD_WAIT until its register clears.
// REGFILE_BYPASS_EN forwards the write bus straight into Source.
module regfile_read_port
  import regfile_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  rd_en,
  input  logic [ADDR_W-1:0]                     rd_addr,
  input  logic [(2**ADDR_W)-1:0][DATA_W-1:0]    regs,
  input  logic [(2**ADDR_W)-1:0]                pending,
  input  logic                                  wr_hit,
  input  logic [ADDR_W-1:0]                     wr_addr,
  input  logic [DATA_W-1:0]                     wr_data,
  output logic [DATA_W-1:0]                     src,
  output logic                                  rd_valid,
  output logic                                  rd_busy
);

  rd_state_t           state, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   src_d;
  logic                valid_d, busy_d;

`ifndef REGFILE_BYPASS_EN
  logic unused_wr_bus;
  assign unused_wr_bus = ^{wr_hit, wr_addr, wr_data};
`endif

  always_comb begin
    state_d = state;
    addr_d  = addr_q;
    src_d   = src;
    valid_d = 1'b0;
    busy_d  = rd_busy;
    case (state)
      RD_IDLE: begin
        if (rd_en) begin
`ifdef REGFILE_BYPASS_EN
          if (wr_hit && wr_addr == rd_addr) begin
            src_d   = wr_data;
            valid_d = 1'b1;
          end else
`endif
          if (!pending[rd_addr]) begin
            src_d   = regs[rd_addr];
            valid_d = 1'b1;
          end else begin
            addr_d  = rd_addr;
            state_d = RD_WAIT;
            busy_d  = 1'b1;
          end
        end
      end
      RD_WAIT: begin
        // rd_en is deliberately ignored while parked on a pending register
`ifdef REGFILE_BYPASS_EN
        if (wr_hit && wr_addr == addr_q) begin
          src_d   = wr_data;
          valid_d = 1'b1;
          busy_d  = 1'b0;
          state_d = RD_IDLE;
        end else
`endif
        if (!pending[addr_q]) begin
          src_d   = regs[addr_q];
          valid_d = 1'b1;
          busy_d  = 1'b0;
          state_d = RD_IDLE;
        end
      end
      default: begin
        state_d = RD_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= RD_IDLE;
      addr_q   <= '0;
      src      <= '0;
      rd_valid <= 1'b0;
      rd_busy  <= 1'b0;
    end else begin
      state    <= state_d;
      addr_q   <= addr_d;
      src      <= src_d;
      rd_valid <= valid_d;
      rd_busy  <= busy_d;
    end
  end

endmodule

// File: rtl/register_bank_sb.sv
// Register file with pending-write scoreboard and RD_PORTS stalling read ports.
// Optional write-to-read forwarding under REGFILE_BYPASS_EN.
module register_bank_sb
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int RD_PORTS = RD_PORTS_DEF,
  parameter int ZERO_REG = 0
) (
  input  logic                         Clock,
  input  logic                         Reset,
  input  logic                         Write_En,
  input  logic [ADDR_W-1:0]            Destination,
  input  logic [DATA_W-1:0]            LDR_MUX,
  input  logic                         Reserve_En,
  input  logic [ADDR_W-1:0]            Reserve_ADDR,
  input  logic [RD_PORTS-1:0]          Read_En,
  input  logic [RD_PORTS*ADDR_W-1:0]   Source_ADDR,
  output logic [RD_PORTS*DATA_W-1:0]   Source,
  output logic [RD_PORTS-1:0]          Read_Valid,
  output logic [RD_PORTS-1:0]          Read_Busy,
  output logic [(2**ADDR_W)-1:0]       Pending_Mask
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DEPTH-1:0][DATA_W-1:0] regs;
  logic [DEPTH-1:0]             pending, pending_d;
  logic                         wr_hit, rsv_hit;

  // Register 0 is hard-wired when ZERO_REG is set: it never takes data or a reservation
  assign wr_hit  = Write_En   && !((ZERO_REG != 0) && (Destination  == '0));
  assign rsv_hit = Reserve_En && !((ZERO_REG != 0) && (Reserve_ADDR == '0));

  // Reserve is applied after the write clear so a same-cycle reserve wins
  always_comb begin
    pending_d = pending;
    if (wr_hit)
      pending_d[Destination] = 1'b0;
    if (rsv_hit)
      pending_d[Reserve_ADDR] = 1'b1;
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      regs    <= '0;
      pending <= '0;
    end else begin
      pending <= pending_d;
      if (wr_hit)
        regs[Destination] <= LDR_MUX;
    end
  end

  assign Pending_Mask = pending;

  for (genvar p = 0; p < RD_PORTS; p++) begin : g_port
    regfile_read_port #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
    ) u_port (
      .clk      (Clock),
      .rst      (Reset),
      .rd_en    (Read_En[p]),
      .rd_addr  (Source_ADDR[p*ADDR_W +: ADDR_W]),
      .regs     (regs),
      .pending  (pending),
      .wr_hit   (wr_hit),
      .wr_addr  (Destination),
      .wr_data  (LDR_MUX),
      .src      (Source[p*DATA_W +: DATA_W]),
      .rd_valid (Read_Valid[p]),
      .rd_busy  (Read_Busy[p])
    );
  end

endmodule

// File: tb/tb_register_bank_sb.sv
// Directed bench for register_bank_sb; expectations follow REGFILE_BYPASS_EN when it is defined.
module tb_register_bank_sb;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 4;
  localparam int RD_PORTS = 2;

  logic                        Clock = 1'b0;
  logic                        Reset = 1'b1;
  logic                        Write_En = 1'b0;
  logic [ADDR_W-1:0]           Destination = '0;
  logic [DATA_W-1:0]           LDR_MUX = '0;
  logic                        Reserve_En = 1'b0;
  logic [ADDR_W-1:0]           Reserve_ADDR = '0;
  logic [RD_PORTS-1:0]         Read_En = '0;
  logic [RD_PORTS*ADDR_W-1:0]  Source_ADDR = '0;
  logic [RD_PORTS*DATA_W-1:0]  Source, z_Source;
  logic [RD_PORTS-1:0]         Read_Valid, Read_Busy, z_Read_Valid, z_Read_Busy;
  logic [(2**ADDR_W)-1:0]      Pending_Mask, z_Pending_Mask;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 Clock = ~Clock;

  register_bank_sb #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .RD_PORTS(RD_PORTS), .ZERO_REG(0)
  ) dut (
    .Clock(Clock), .Reset(Reset), .Write_En(Write_En), .Destination(Destination),
    .LDR_MUX(LDR_MUX), .Reserve_En(Reserve_En), .Reserve_ADDR(Reserve_ADDR),
    .Read_En(Read_En), .Source_ADDR(Source_ADDR), .Source(Source),
    .Read_Valid(Read_Valid), .Read_Busy(Read_Busy), .Pending_Mask(Pending_Mask)
  );

  register_bank_sb #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .RD_PORTS(RD_PORTS), .ZERO_REG(1)
  ) dut_z (
    .Clock(Clock), .Reset(Reset), .Write_En(Write_En), .Destination(Destination),
    .LDR_MUX(LDR_MUX), .Reserve_En(Reserve_En), .Reserve_ADDR(Reserve_ADDR),
    .Read_En(Read_En), .Source_ADDR(Source_ADDR), .Source(z_Source),
    .Read_Valid(z_Read_Valid), .Read_Busy(z_Read_Busy), .Pending_Mask(z_Pending_Mask)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge Clock);
    @(negedge Clock);
  endtask

  task automatic set_read(input logic [1:0] en, input logic [3:0] a0, input logic [3:0] a1);
    Read_En     = en;
    Source_ADDR = {a1, a0};
  endtask

  initial begin
    // 1: reset state, then every register reads zero on both ports
    @(negedge Clock);
    check("rst_source",  Source,       64'h0);
    check("rst_valid",   Read_Valid,   2'b00);
    check("rst_busy",    Read_Busy,    2'b00);
    check("rst_pending", Pending_Mask, 16'h0);
    @(negedge Clock);
    Reset = 1'b0;
    for (int i = 0; i < 16; i++) begin
      set_read(2'b11, 4'(i), 4'(i));
      tick();
      set_read(2'b00, 4'd0, 4'd0);
      check($sformatf("t1_valid_r%0d", i), Read_Valid, 2'b11);
      check($sformatf("t1_src_r%0d", i),   Source,     64'h0);
      tick();
      check($sformatf("t1_pulse_r%0d", i), Read_Valid, 2'b00);
    end

    // 2: write then plain read
    Write_En = 1'b1; Destination = 4'd5; LDR_MUX = 32'hDEADBEEF;
    tick();
    Write_En = 1'b0;
    set_read(2'b01, 4'd5, 4'd0);
    tick();
    set_read(2'b00, 4'd0, 4'd0);
    check("t2_valid0", Read_Valid[0], 1'b1);
    check("t2_src0",   Source[31:0],  32'hDEADBEEF);
    check("t2_busy0",  Read_Busy[0],  1'b0);

    // 3: reserve, stalled read, resolving write
    Reserve_En = 1'b1; Reserve_ADDR = 4'd3;
    tick();
    Reserve_En = 1'b0;
    check("t3_pend3", Pending_Mask[3], 1'b1);
    set_read(2'b10, 4'd0, 4'd3);
    tick();
    set_read(2'b00, 4'd0, 4'd0);
    check("t3_busy1",   Read_Busy[1],  1'b1);
    check("t3_novalid", Read_Valid[1], 1'b0);
    tick();
    tick();
    check("t3_still_busy", Read_Busy[1], 1'b1);
    Write_En = 1'b1; Destination = 4'd3; LDR_MUX = 32'h12345678;
    tick();
    Write_En = 1'b0;
`ifndef REGFILE_BYPASS_EN
    check("t3_wr_edge_valid", Read_Valid[1], 1'b0);
    check("t3_wr_edge_busy",  Read_Busy[1],  1'b1);
    tick();
`endif
    check("t3_valid1", Read_Valid[1], 1'b1);
    check("t3_src1",   Source[63:32], 32'h12345678);
    check("t3_unbusy", Read_Busy[1],  1'b0);
    check("t3_pend3c", Pending_Mask[3], 1'b0);
    tick();
    check("t3_pulse", Read_Valid[1], 1'b0);

    // 4: same-cycle write and read of reg7
    Write_En = 1'b1; Destination = 4'd7; LDR_MUX = 32'h1;
    tick();
    LDR_MUX = 32'hA5A5A5A5;
    set_read(2'b01, 4'd7, 4'd0);
    tick();
    Write_En = 1'b0;
    set_read(2'b00, 4'd0, 4'd0);
    check("t4_valid0", Read_Valid[0], 1'b1);
`ifdef REGFILE_BYPASS_EN
    check("t4_src0", Source[31:0], 32'hA5A5A5A5);
`else
    check("t4_src0", Source[31:0], 32'h1);
`endif
    set_read(2'b01, 4'd7, 4'd0);
    tick();
    set_read(2'b00, 4'd0, 4'd0);
    check("t4_reread", Source[31:0], 32'hA5A5A5A5);

    // 5: same-cycle write and reserve of reg9 leaves it pending
    Write_En = 1'b1; Destination = 4'd9; LDR_MUX = 32'h99;
    Reserve_En = 1'b1; Reserve_ADDR = 4'd9;
    tick();
    Write_En = 1'b0; Reserve_En = 1'b0;
    check("t5_pend9", Pending_Mask, 16'h0200);
    set_read(2'b01, 4'd9, 4'd0);
    tick();
    set_read(2'b00, 4'd0, 4'd0);
    check("t5_busy0",   Read_Busy[0],  1'b1);
    check("t5_novalid", Read_Valid[0], 1'b0);
    Write_En = 1'b1; Destination = 4'd9; LDR_MUX = 32'h77;
    tick();
    Write_En = 1'b0;
`ifndef REGFILE_BYPASS_EN
    check("t5_wr_edge_valid", Read_Valid[0], 1'b0);
    tick();
`endif
    check("t5_valid0", Read_Valid[0], 1'b1);
    check("t5_src0",   Source[31:0],  32'h77);

    // 6: reset while port0 waits on reg2
    Reserve_En = 1'b1; Reserve_ADDR = 4'd2;
    tick();
    Reserve_En = 1'b0;
    set_read(2'b01, 4'd2, 4'd0);
    tick();
    set_read(2'b00, 4'd0, 4'd0);
    check("t6_busy0", Read_Busy[0], 1'b1);
    Reset = 1'b1;
    #1;
    check("t6_rst_busy",   Read_Busy,    2'b00);
    check("t6_rst_valid",  Read_Valid,   2'b00);
    check("t6_rst_source", Source,       64'h0);
    check("t6_rst_pend",   Pending_Mask, 16'h0);
    @(negedge Clock);
    check("t6_rst_hold_valid", Read_Valid, 2'b00);
    Reset = 1'b0;
    check("t6_pend_after", Pending_Mask, 16'h0);
    set_read(2'b11, 4'd2, 4'd5);
    tick();
    set_read(2'b00, 4'd0, 4'd0);
    check("t6_valid", Read_Valid, 2'b11);
    check("t6_src",   Source,     64'h0);

    // 7: register 0 with ZERO_REG=1 versus ordinary register 0
    Write_En = 1'b1; Destination = 4'd0; LDR_MUX = 32'hFFFF;
    Reserve_En = 1'b1; Reserve_ADDR = 4'd0;
    tick();
    Write_En = 1'b0; Reserve_En = 1'b0;
    check("t7_z_pend0", z_Pending_Mask, 16'h0);
    check("t7_pend0",   Pending_Mask,   16'h0001);
    set_read(2'b01, 4'd0, 4'd0);
    tick();
    set_read(2'b00, 4'd0, 4'd0);
    check("t7_z_valid0", z_Read_Valid[0], 1'b1);
    check("t7_z_src0",   z_Source[31:0],  32'h0);
    check("t7_busy0",    Read_Busy[0],    1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
